// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared constants and types for the timer status stage.
//   CNT_W_DEF / EVT_W_DEF : default counter and event-counter widths
//   TSR_OVF / TSR_UNF     : bit positions of the sticky flags inside TSR
//   TSR_W                 : width of the TSR write data
//   CNT_MAX / CNT_MIN     : wrap limits of a CNT_W_DEF-bit counter
//   dir_e                 : Up_Down encoding (UP = 0, DOWN = 1)
// ---------------------------------------------------------------------------
package timer_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int EVT_W_DEF = 8;

  localparam int TSR_W   = 2;
  localparam int TSR_OVF = 0;
  localparam int TSR_UNF = 1;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};
  localparam logic [CNT_W_DEF-1:0] CNT_MIN = {CNT_W_DEF{1'b0}};

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/timer_status_if.sv
// ---------------------------------------------------------------------------
// timer_status_if
// Register-file side of the timer status stage.
//   tsr_wr     : one-cycle write strobe to TSR
//   tsr_wdata  : TSR write data, write-0-to-clear (bit0 OVF, bit1 UNF)
//   ovf_ie     : overflow interrupt enable
//   unf_ie     : underflow interrupt enable
//   s_tmr_ovf  : sticky overflow flag (TSR[0])
//   s_tmr_unf  : sticky underflow flag (TSR[1])
//   irq        : level interrupt request
// master = APB register file, slave = timer_status.
// ---------------------------------------------------------------------------
interface timer_status_if;
  import timer_pkg::*;

  logic             tsr_wr;
  logic [TSR_W-1:0] tsr_wdata;
  logic             ovf_ie;
  logic             unf_ie;
  logic             s_tmr_ovf;
  logic             s_tmr_unf;
  logic             irq;

  modport master (
    output tsr_wr, tsr_wdata, ovf_ie, unf_ie,
    input  s_tmr_ovf, s_tmr_unf, irq
  );

  modport slave (
    input  tsr_wr, tsr_wdata, ovf_ie, unf_ie,
    output s_tmr_ovf, s_tmr_unf, irq
  );

endinterface

// File: rtl/timer_wrap_detect.sv
// ---------------------------------------------------------------------------
// timer_wrap_detect
// Compares the counter value of this cycle with the value of the previous
// cycle and produces single-cycle overflow / underflow pulses.
//   clk, rst_n : clock, asynchronous active-low reset
//   tcnt       : current counter value
//   up_down    : counting direction (see timer_pkg::dir_e)
//   en         : counter enable
//   load       : counter load strobe
//   ovf_evt    : up-count wrap all-ones -> zero seen this cycle
//   unf_evt    : down-count wrap zero -> all-ones seen this cycle
// ---------------------------------------------------------------------------
module timer_wrap_detect
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] tcnt,
  input  logic             up_down,
  input  logic             en,
  input  logic             load,
  output logic             ovf_evt,
  output logic             unf_evt
);

  localparam logic [CNT_W-1:0] WRAP_HI = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WRAP_LO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             load_q, load_d;
  logic             prev_valid_q, prev_valid_d;

  // History is just last cycle's inputs; prev_valid keeps the reset value
  // of tcnt_q from being mistaken for a real previous count.
  always_comb begin
    tcnt_d       = tcnt;
    load_d       = load;
    prev_valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q       <= '0;
      load_q       <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      tcnt_q       <= tcnt_d;
      load_q       <= load_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  // load_q set means the current tcnt came from TDR, so any apparent wrap
  // is a load artefact and must be ignored.
  always_comb begin
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (prev_valid_q && !load_q && en) begin
      if (up_down == UP && tcnt_q == WRAP_HI && tcnt == WRAP_LO) begin
        ovf_evt = 1'b1;
      end
      if (up_down == DOWN && tcnt_q == WRAP_LO && tcnt == WRAP_HI) begin
        unf_evt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_status.sv
// ---------------------------------------------------------------------------
// timer_status
// Status stage behind the 8-bit timer counter: sticky TSR overflow and
// underflow flags (write-0-to-clear, set wins over clear) and a level
// interrupt gated by per-flag enables.
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   TCNT          : current counter value
//   Up_Down       : 1 = down-count, 0 = up-count
//   EN            : counter enable
//   Load          : counter load strobe
//   bus           : timer_status_if.slave (TSR write, enables, flags, irq)
//   evt_cnt       : saturating event counter, only with the macro below
// Optional feature macro: TIMER_STATUS_EVT_CNT_EN adds evt_cnt.
// ---------------------------------------------------------------------------
module timer_status
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
`ifdef TIMER_STATUS_EVT_CNT_EN
  ,
  parameter int EVT_W = EVT_W_DEF
`endif
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [CNT_W-1:0] TCNT,
  input  logic             Up_Down,
  input  logic             EN,
  input  logic             Load,
  timer_status_if.slave    bus
`ifdef TIMER_STATUS_EVT_CNT_EN
  ,
  output logic [EVT_W-1:0] evt_cnt
`endif
);

  logic ovf_evt, unf_evt;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  timer_wrap_detect #(
    .CNT_W (CNT_W)
  ) u_wrap_detect (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .tcnt    (TCNT),
    .up_down (Up_Down),
    .en      (EN),
    .load    (Load),
    .ovf_evt (ovf_evt),
    .unf_evt (unf_evt)
  );

  // Write-0-to-clear; the event is applied after the clear so that a new
  // event in the same cycle as a clearing write keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.tsr_wr && !bus.tsr_wdata[TSR_OVF]) begin
      ovf_d = 1'b0;
    end
    if (bus.tsr_wr && !bus.tsr_wdata[TSR_UNF]) begin
      unf_d = 1'b0;
    end
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end
    if (unf_evt) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.s_tmr_ovf = ovf_q;
  assign bus.s_tmr_unf = unf_q;

  // Built only from flops and the enable inputs, so TCNT cannot glitch it;
  // the enables are used live so toggling them acts in the same cycle.
  assign bus.irq = (ovf_q & bus.ovf_ie) | (unf_q & bus.unf_ie);

`ifdef TIMER_STATUS_EVT_CNT_EN
  localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};

  logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic             evt_any;
  logic             evt_clr;

  // A full clear (write of all zeros) restarts the count; an event in the
  // same cycle is counted on top of the clear rather than lost.
  always_comb begin
    evt_any   = ovf_evt | unf_evt;
    evt_clr   = bus.tsr_wr && (bus.tsr_wdata == '0);
    evt_cnt_d = evt_cnt_q;
    if (evt_clr) begin
      evt_cnt_d = evt_any ? EVT_W'(1) : '0;
    end else if (evt_any && evt_cnt_q != EVT_MAX) begin
      evt_cnt_d = evt_cnt_q + EVT_W'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      evt_cnt_q <= '0;
    end else begin
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign evt_cnt = evt_cnt_q;
`endif

endmodule

// File: tb/tb_timer_status.sv
// ---------------------------------------------------------------------------
// tb_timer_status
// Self-checking bench for timer_status. A behavioural model tracks the
// previous counter sample and applies the wrap / clear rules with plain
// integer arithmetic. Define TIMER_STATUS_EVT_CNT_EN to also cover evt_cnt.
// ---------------------------------------------------------------------------
module tb_timer_status;
  import timer_pkg::*;

  localparam int TOP = (1 << CNT_W_DEF) - 1;

  logic                 PCLK = 1'b0;
  logic                 PRESETn;
  logic [CNT_W_DEF-1:0] TCNT;
  logic                 Up_Down;
  logic                 EN;
  logic                 Load;
`ifdef TIMER_STATUS_EVT_CNT_EN
  logic [EVT_W_DEF-1:0] evt_cnt;
`endif

  timer_status_if bus ();

  timer_status dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .TCNT    (TCNT),
    .Up_Down (Up_Down),
    .EN      (EN),
    .Load    (Load),
    .bus     (bus)
`ifdef TIMER_STATUS_EVT_CNT_EN
    ,
    .evt_cnt (evt_cnt)
`endif
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_prev_tcnt;
  bit m_prev_load;
  bit m_valid;
  bit m_ovf;
  bit m_unf;
  int m_evt;

  task automatic model_reset();
    m_prev_tcnt = 0;
    m_prev_load = 1'b0;
    m_valid     = 1'b0;
    m_ovf       = 1'b0;
    m_unf       = 1'b0;
    m_evt       = 0;
  endtask

  // Applies one clock edge to the model using the inputs present at it.
  task automatic model_edge();
    int  cur;
    bit  counting, wrapped_up, wrapped_down, wr;
    cur          = int'(TCNT);
    counting     = m_valid && !m_prev_load && EN;
    wrapped_up   = counting && !Up_Down && m_prev_tcnt == TOP && cur == 0;
    wrapped_down = counting &&  Up_Down && m_prev_tcnt == 0 && cur == TOP;
    wr           = bus.tsr_wr;
    if (wrapped_up) m_ovf = 1'b1;
    else if (wr && !bus.tsr_wdata[0]) m_ovf = 1'b0;
    if (wrapped_down) m_unf = 1'b1;
    else if (wr && !bus.tsr_wdata[1]) m_unf = 1'b0;
    if (wr && bus.tsr_wdata == 2'b00) m_evt = (wrapped_up || wrapped_down) ? 1 : 0;
    else if ((wrapped_up || wrapped_down) && m_evt < 255) m_evt = m_evt + 1;
    m_prev_tcnt = cur;
    m_prev_load = Load;
    m_valid     = 1'b1;
  endtask

  function automatic bit model_irq();
    return (m_ovf && bus.ovf_ie) || (m_unf && bus.unf_ie);
  endfunction

  task automatic step();
    @(posedge PCLK);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    PRESETn       = 1'b0;
    TCNT          = '0;
    Up_Down       = 1'b0;
    EN            = 1'b0;
    Load          = 1'b0;
    bus.tsr_wr    = 1'b0;
    bus.tsr_wdata = 2'b11;
    bus.ovf_ie    = 1'b1;
    bus.unf_ie    = 1'b1;
    model_reset();
    #12;
    n_checks++;
    if (bus.s_tmr_ovf !== 1'b0) begin
      n_errors++; $display("[TB] FAIL reset_ovf got=%b exp=0", bus.s_tmr_ovf);
    end
    n_checks++;
    if (bus.s_tmr_unf !== 1'b0) begin
      n_errors++; $display("[TB] FAIL reset_unf got=%b exp=0", bus.s_tmr_unf);
    end
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_errors++; $display("[TB] FAIL reset_irq got=%b exp=0", bus.irq);
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  task automatic test_overflow();
    EN = 1'b1; Up_Down = 1'b0; bus.ovf_ie = 1'b1; bus.unf_ie = 1'b0;
    TCNT = 8'hFE; step();
    TCNT = 8'hFF; step();
    TCNT = 8'h00;
    #1;
    n_checks++;
    if (bus.s_tmr_ovf !== 1'b0) begin
      n_errors++; $display("[TB] FAIL ovf_early got=%b exp=0", bus.s_tmr_ovf);
    end
    step();
    n_checks++;
    if (bus.s_tmr_ovf !== 1'b1 || m_ovf !== 1'b1) begin
      n_errors++; $display("[TB] FAIL ovf_set got=%b exp=1", bus.s_tmr_ovf);
    end
    n_checks++;
    if (bus.irq !== 1'b1) begin
      n_errors++; $display("[TB] FAIL ovf_irq got=%b exp=1", bus.irq);
    end
    n_checks++;
    if (bus.s_tmr_unf !== 1'b0) begin
      n_errors++; $display("[TB] FAIL ovf_unf_quiet got=%b exp=0", bus.s_tmr_unf);
    end
    TCNT = 8'h01; step();
    n_checks++;
    if (bus.s_tmr_ovf !== 1'b1) begin
      n_errors++; $display("[TB] FAIL ovf_sticky got=%b exp=1", bus.s_tmr_ovf);
    end
  endtask

  task automatic test_underflow();
    Up_Down = 1'b1; bus.ovf_ie = 1'b0; bus.unf_ie = 1'b0;
    TCNT = 8'h01; step();
    TCNT = 8'h00; step();
    TCNT = 8'hFF; step();
    TCNT = 8'hFE; step();
    n_checks++;
    if (bus.s_tmr_unf !== 1'b1) begin
      n_errors++; $display("[TB] FAIL unf_set got=%b exp=1", bus.s_tmr_unf);
    end
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_errors++; $display("[TB] FAIL unf_irq_masked got=%b exp=0", bus.irq);
    end
    bus.unf_ie = 1'b1;
    #1;
    n_checks++;
    if (bus.irq !== 1'b1) begin
      n_errors++; $display("[TB] FAIL unf_irq_enable got=%b exp=1", bus.irq);
    end
    bus.ovf_ie = 1'b1; bus.unf_ie = 1'b0;
    #1;
    n_checks++;
    if (bus.irq !== 1'b1) begin
      n_errors++; $display("[TB] FAIL ovf_irq_raise got=%b exp=1", bus.irq);
    end
    bus.ovf_ie = 1'b0;
    #1;
    n_checks++;
    if (bus.irq !== 1'b0 || bus.s_tmr_ovf !== 1'b1) begin
      n_errors++; $display("[TB] FAIL ovf_irq_drop got irq=%b ovf=%b exp irq=0 ovf=1", bus.irq, bus.s_tmr_ovf);
    end
  endtask

  task automatic test_load_mask();
    bus.tsr_wr = 1'b1; bus.tsr_wdata = 2'b00; TCNT = 8'h10; step();
    bus.tsr_wr = 1'b0; bus.tsr_wdata = 2'b11;
    Up_Down = 1'b0;
    TCNT = 8'hFF; Load = 1'b1; step();
    TCNT = 8'h00; Load = 1'b0; step();
    step();
    n_checks++;
    if (bus.s_tmr_ovf !== 1'b0) begin
      n_errors++; $display("[TB] FAIL load_mask_ovf got=%b exp=0", bus.s_tmr_ovf);
    end
    Up_Down = 1'b1;
    TCNT = 8'h00; Load = 1'b1; step();
    TCNT = 8'hFF; Load = 1'b0; step();
    step();
    n_checks++;
    if (bus.s_tmr_unf !== 1'b0) begin
      n_errors++; $display("[TB] FAIL load_mask_unf got=%b exp=0", bus.s_tmr_unf);
    end
    Up_Down = 1'b0; EN = 1'b0;
    TCNT = 8'hFF; step();
    TCNT = 8'h00; step();
    step();
    n_checks++;
    if (bus.s_tmr_ovf !== 1'b0) begin
      n_errors++; $display("[TB] FAIL en_low_ovf got=%b exp=0", bus.s_tmr_ovf);
    end
    EN = 1'b1;
  endtask

  task automatic test_clear();
    Up_Down = 1'b0;
    TCNT = 8'hFF; step();
    TCNT = 8'h00; step();
    Up_Down = 1'b1;
    TCNT = 8'hFF; step();
    step();
    bus.tsr_wr = 1'b1; bus.tsr_wdata = 2'b10; step();
    bus.tsr_wr = 1'b0; bus.tsr_wdata = 2'b11;
    n_checks++;
    if (bus.s_tmr_ovf !== 1'b0 || bus.s_tmr_unf !== 1'b1) begin
      n_errors++; $display("[TB] FAIL clear_ovf got ovf=%b unf=%b exp ovf=0 unf=1", bus.s_tmr_ovf, bus.s_tmr_unf);
    end
    Up_Down = 1'b0;
    TCNT = 8'hFF; step();
    TCNT = 8'h00; bus.tsr_wr = 1'b1; bus.tsr_wdata = 2'b10; step();
    bus.tsr_wr = 1'b0; bus.tsr_wdata = 2'b11;
    n_checks++;
    if (bus.s_tmr_ovf !== 1'b1) begin
      n_errors++; $display("[TB] FAIL set_wins got=%b exp=1", bus.s_tmr_ovf);
    end
    bus.tsr_wr = 1'b1; bus.tsr_wdata = 2'b01; step();
    bus.tsr_wr = 1'b0; bus.tsr_wdata = 2'b11;
    n_checks++;
    if (bus.s_tmr_ovf !== 1'b1 || bus.s_tmr_unf !== 1'b0) begin
      n_errors++; $display("[TB] FAIL clear_unf got ovf=%b unf=%b exp ovf=1 unf=0", bus.s_tmr_ovf, bus.s_tmr_unf);
    end
  endtask

  task automatic test_reset_mid();
    Up_Down = 1'b1;
    TCNT = 8'h00; step();
    TCNT = 8'hFF; step();
    Up_Down = 1'b0;
    step();
    bus.ovf_ie = 1'b1; bus.unf_ie = 1'b1;
    #2;
    PRESETn = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.s_tmr_ovf !== 1'b0 || bus.s_tmr_unf !== 1'b0 || bus.irq !== 1'b0) begin
      n_errors++; $display("[TB] FAIL async_reset got ovf=%b unf=%b irq=%b exp all 0", bus.s_tmr_ovf, bus.s_tmr_unf, bus.irq);
    end
    TCNT = 8'h00;
    @(negedge PCLK);
    PRESETn = 1'b1;
    step();
    step();
    n_checks++;
    if (bus.s_tmr_ovf !== 1'b0 || bus.irq !== 1'b0) begin
      n_errors++; $display("[TB] FAIL release_no_evt got ovf=%b irq=%b exp 0", bus.s_tmr_ovf, bus.irq);
    end
  endtask

  task automatic test_random();
    int cnt;
    int tdr;
    cnt = int'(TCNT);
    tdr = 0;
    for (int i = 0; i < 1200; i++) begin
      if (Load) cnt = tdr;
      else if (EN) cnt = Up_Down ? (cnt + TOP) % (TOP + 1) : (cnt + 1) % (TOP + 1);
      TCNT = CNT_W_DEF'(cnt);
      EN = ($urandom % 8) != 0;
      if (($urandom % 16) == 0) Up_Down = ~Up_Down;
      Load = ($urandom % 10) == 0;
      case ($urandom % 5)
        0: tdr = 0;
        1: tdr = TOP;
        2: tdr = 1;
        3: tdr = TOP - 1;
        default: tdr = int'($urandom % (TOP + 1));
      endcase
      bus.tsr_wr    = ($urandom % 12) == 0;
      bus.tsr_wdata = 2'($urandom % 4);
      if (($urandom % 8) == 0) bus.ovf_ie = 1'($urandom % 2);
      if (($urandom % 8) == 0) bus.unf_ie = 1'($urandom % 2);
      step();
      n_checks++;
      if (bus.s_tmr_ovf !== m_ovf) begin
        n_errors++; $display("[TB] FAIL rand_ovf cyc=%0d got=%b exp=%b", i, bus.s_tmr_ovf, m_ovf);
      end
      n_checks++;
      if (bus.s_tmr_unf !== m_unf) begin
        n_errors++; $display("[TB] FAIL rand_unf cyc=%0d got=%b exp=%b", i, bus.s_tmr_unf, m_unf);
      end
      n_checks++;
      if (bus.irq !== model_irq()) begin
        n_errors++; $display("[TB] FAIL rand_irq cyc=%0d got=%b exp=%b", i, bus.irq, model_irq());
      end
`ifdef TIMER_STATUS_EVT_CNT_EN
      n_checks++;
      if (int'(evt_cnt) != m_evt) begin
        n_errors++; $display("[TB] FAIL rand_evt cyc=%0d got=%0d exp=%0d", i, evt_cnt, m_evt);
      end
`endif
    end
    Load = 1'b0; bus.tsr_wr = 1'b0; bus.tsr_wdata = 2'b11; EN = 1'b1;
    step();
  endtask

`ifdef TIMER_STATUS_EVT_CNT_EN
  task automatic test_evt_cnt();
    TCNT = 8'h40; bus.tsr_wr = 1'b1; bus.tsr_wdata = 2'b00; step();
    bus.tsr_wr = 1'b0; bus.tsr_wdata = 2'b11;
    Up_Down = 1'b0; EN = 1'b1; Load = 1'b0;
    for (int i = 0; i < 300; i++) begin
      TCNT = 8'hFF; step();
      TCNT = 8'h00; step();
    end
    step();
    n_checks++;
    if (evt_cnt !== 8'hFF || m_evt != 255) begin
      n_errors++; $display("[TB] FAIL evt_saturate got=%0d exp=255", evt_cnt);
    end
    bus.tsr_wr = 1'b1; bus.tsr_wdata = 2'b00; step();
    bus.tsr_wr = 1'b0; bus.tsr_wdata = 2'b11;
    n_checks++;
    if (evt_cnt !== 8'h00) begin
      n_errors++; $display("[TB] FAIL evt_clear got=%0d exp=0", evt_cnt);
    end
    TCNT = 8'hFF; step();
    TCNT = 8'h00; bus.tsr_wr = 1'b1; bus.tsr_wdata = 2'b00; step();
    bus.tsr_wr = 1'b0; bus.tsr_wdata = 2'b11;
    n_checks++;
    if (evt_cnt !== 8'h01) begin
      n_errors++; $display("[TB] FAIL evt_clear_evt got=%0d exp=1", evt_cnt);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_overflow();
    test_underflow();
    test_load_mask();
    test_clear();
    test_reset_mid();
`ifdef TIMER_STATUS_EVT_CNT_EN
    test_evt_cnt();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_status.md
Name: timer_status

Overview:
- Status/flag stage directly downstream of the 8-bit timer counter.
- Watches TCNT each PCLK and detects overflow (up-count wrap 0xFF->0x00) and underflow (down-count wrap 0x00->0xFF).
- Holds the sticky TSR flags that are fed back to the counter as s_tmr_ovf / s_tmr_unf; the APB register file reads and clears them.
- Drives a level interrupt gated by per-flag enables.

Parameters:
- CNT_W, 8, counter width; the wrap limits are all-ones and zero at this width.
- EVT_W, 8, width of the saturating event counter (Optional Feature only).

Ports:
- PCLK  in  1  system clock; all state on rising edge
- PRESETn  in  1  asynchronous active-low reset
- TCNT  in  CNT_W  current counter value (registered in the counter, same clock)
- Up_Down  in  1  1 = down-count, 0 = up-count
- EN  in  1  counter enable
- Load  in  1  counter load strobe (TDR -> TCNT this edge)
- tsr_wr  in  1  APB write strobe to TSR, one PCLK wide
- tsr_wdata  in  2  write data; bit0 = OVF, bit1 = UNF
- ovf_ie  in  1  overflow interrupt enable
- unf_ie  in  1  underflow interrupt enable
- s_tmr_ovf  out  1  sticky overflow flag (TSR[0])
- s_tmr_unf  out  1  sticky underflow flag (TSR[1])
- irq  out  1  interrupt request, level

Behaviour:
- Clock and reset: one clock, PCLK. Reset is asynchronous and active-low on PRESETn.
- Reset values: s_tmr_ovf = 0, s_tmr_unf = 0, irq = 0. Internal tcnt_q = 0, load_q = 0, prev_valid = 0.
- Every edge: tcnt_q <= TCNT, load_q <= Load, prev_valid <= 1.
- Overflow event (combinational, cycle k):
  - prev_valid && !load_q && EN && !Up_Down && tcnt_q == all-ones && TCNT == 0.
- Underflow event (combinational, cycle k):
  - prev_valid && !load_q && EN && Up_Down && tcnt_q == 0 && TCNT == all-ones.
- Latency: TCNT wraps at edge k. The event is visible during cycle k. The flag is set at edge k+1. irq rises in the same cycle as the flag.
- Load masking: a TCNT change caused by Load is never an event. This covers loading 0x00 while TCNT = 0xFF, and loading 0xFF while TCNT = 0x00.
- Non-wrap steps (e.g. 0x7F->0x80) and the counter holding its value never set flags.
- Clear semantics are write-0-to-clear:
  - tsr_wr with tsr_wdata[i] = 0 clears flag i.
  - tsr_wdata[i] = 1 leaves flag i unchanged.
- Simultaneous set and clear of the same flag in one cycle: set wins, flag stays 1.
- Flags are sticky. A second event while a flag is already set has no further effect.
- irq = (s_tmr_ovf & ovf_ie) | (s_tmr_unf & unf_ie). It is a pure function of registers and enable inputs: no glitch path from TCNT.
- Enables are not latched:
  - Dropping ovf_ie deasserts irq the same cycle; the flag is kept.
  - Raising ovf_ie with the flag already set asserts irq the same cycle.
- Reset mid-operation: all flags and history clear immediately (asynchronous). The first cycle after release has prev_valid = 0, so no event is possible.
- EN low: no events, even if TCNT changes. TCNT should only change via Load when EN is low, and Load is masked anyway.

Optional Feature:
- Macro: TIMER_STATUS_EVT_CNT_EN.
- Defined:
  - Adds output evt_cnt [EVT_W-1:0], reset 0.
  - Increments by 1 on each overflow or underflow event.
  - Saturates at all-ones.
  - Cleared to 0 on any tsr_wr whose tsr_wdata == 2'b00. If an event occurs in the same cycle, evt_cnt <= 1.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package timer_pkg:
  - CNT_W default.
  - TSR bit indices (TSR_OVF = 0, TSR_UNF = 1).
  - Wrap constants CNT_MAX and CNT_MIN.
  - Up_Down encoding (UP = 0, DOWN = 1).
- One natural sub-module: timer_wrap_detect. It holds tcnt_q, load_q and prev_valid, and outputs single-cycle ovf_evt / unf_evt pulses. The top keeps the sticky flags, irq and the optional counter.

Test Plan:
- Reset, then EN = 1, Up_Down = 0, TCNT steps 0xFE->0xFF->0x00 -> s_tmr_ovf = 1 exactly one edge after TCNT = 0x00. With ovf_ie = 1, irq = 1 the same cycle; s_tmr_unf stays 0.
- Up_Down = 1, TCNT 0x01->0x00->0xFF, unf_ie = 0 -> s_tmr_unf = 1, irq = 0. Then set unf_ie = 1 -> irq = 1 immediately.
- TCNT = 0xFF, Load = 1 with TDR = 0x00 (TCNT becomes 0x00) -> no flag set. Repeat with 0x00 -> 0xFF on Load -> no flag set.
- s_tmr_ovf = 1, tsr_wr = 1 with tsr_wdata = 2'b10 -> ovf clears next edge, unf unchanged. Repeat the write in the same cycle as a new 0xFF->0x00 wrap -> ovf remains 1.
- Deassert PRESETn mid-count with both flags set -> flags and irq go to 0 asynchronously. Release with TCNT = 0x00 while its previous value was 0xFF -> no flag in the first cycle.
- TIMER_STATUS_EVT_CNT_EN: 300 overflow wraps -> evt_cnt = 0xFF (saturated). Write tsr_wdata = 2'b00 -> evt_cnt = 0.
